// File: rtl/fir_mac_ctrl.sv
// Single-multiplier FIR sequencer: TAPS-deep delay line, coefficient ROM addressing,
// wide accumulation and round-half-up conversion. Define MAC_SAT_EN to clamp instead of wrap.
module fir_mac_ctrl #(
  parameter int N      = 16,
  parameter int M      = 7,
  parameter int F      = 8,
  parameter int TAPS   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [N-1:0]      x_in,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [N-1:0]      coef_data,
  output logic [N-1:0]      y_out,
  output logic              done,
  output logic              busy
);

  localparam int ACC_W = 2*N + $clog2(TAPS);
  localparam int QW    = M + F + 1;
  localparam logic [ADDR_W-1:0]       LAST = ADDR_W'(TAPS-1);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2**(F-1));

  typedef enum logic [1:0] {IDLE, FETCH, MAC, ROUND} state_t;

  state_t                    state, state_next;
  logic signed [N-1:0]       x_dl [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic [ADDR_W-1:0]         k;
  logic signed [2*N-1:0]     prod;
  logic [N-1:0]              y_conv;

  assign prod = $signed(coef_data) * x_dl[k];
  assign busy = (state != IDLE);

`ifdef MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] YMAX = ACC_W'(2**(QW-1) - 1);
  localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

  logic signed [ACC_W-1:0] rnd;

  always_comb begin
    rnd = (acc + HALF) >>> F;
    if (rnd > YMAX)
      y_conv = QW'(YMAX);
    else if (rnd < YMIN)
      y_conv = QW'(YMIN);
    else
      y_conv = QW'(rnd);
  end
`else
  // Two's-complement wrap: only the low bits of the rounded sum survive.
  always_comb begin
    y_conv = QW'((acc + HALF) >>> F);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !clear) state_next = FETCH;
      FETCH:   state_next = MAC;
      MAC:     if (k == LAST) state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The ROM is one cycle behind coef_addr, so the address always runs one tap ahead of k.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++)
        x_dl[i] <= '0;
      acc       <= '0;
      k         <= '0;
      coef_addr <= '0;
      y_out     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < TAPS; i++)
              x_dl[i] <= '0;
          end else if (start) begin
            for (int i = TAPS-1; i > 0; i--)
              x_dl[i] <= x_dl[i-1];
            x_dl[0]   <= x_in;
            acc       <= '0;
            k         <= '0;
            coef_addr <= '0;
          end
        end
        FETCH: begin
          coef_addr <= ADDR_W'(1);
        end
        MAC: begin
          acc <= acc + {{(ACC_W-2*N){prod[2*N-1]}}, prod};
          k   <= k + ADDR_W'(1);
          if (coef_addr != LAST)
            coef_addr <= coef_addr + ADDR_W'(1);
        end
        ROUND: begin
          y_out <= y_conv;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench for fir_mac_ctrl: a sample-level FIR model compared every cycle,
// plus hand-computed expectations for impulse, rounding, overflow, busy-start, reset and clear.
module tb_fir_mac_ctrl;

  localparam int N = 16, M = 7, F = 8, TAPS = 8, ADDR_W = 3;
  localparam int LAT = TAPS + 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              clear = 1'b0;
  logic [N-1:0]      x_in = '0;
  logic [ADDR_W-1:0] coef_addr;
  logic [N-1:0]      coef_data = '0;
  logic [N-1:0]      y_out;
  logic              done;
  logic              busy;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] rom [TAPS];

  always #5 clk = ~clk;

  fir_mac_ctrl #(.N(N), .M(M), .F(F), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .x_in(x_in),
    .coef_addr(coef_addr), .coef_data(coef_data), .y_out(y_out),
    .done(done), .busy(busy)
  );

  // Synchronous coefficient ROM
  always @(posedge clk) coef_data <= rom[coef_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sample history, output value and when it must appear
  logic signed [N-1:0] hist [TAPS];
  int                  phase = 0;
  logic                exp_done = 1'b0;
  logic [N-1:0]        exp_y = '0;
  logic [N-1:0]        pend_y = '0;
  logic [ADDR_W-1:0]   exp_addr = '0;

  initial for (int i = 0; i < TAPS; i++) hist[i] = '0;

  function automatic logic [N-1:0] modelY();
    longint sum = 0;
    longint r;
    for (int i = 0; i < TAPS; i++)
      sum += longint'($signed(rom[i])) * longint'(hist[i]);
    r = (sum + (longint'(1) << (F-1))) >>> F;
`ifdef MAC_SAT_EN
    if (r > (longint'(1) << (N-1)) - 1) r = (longint'(1) << (N-1)) - 1;
    else if (r < -(longint'(1) << (N-1))) r = -(longint'(1) << (N-1));
`endif
    return r[N-1:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase = 0; exp_done = 1'b0; exp_y = '0; exp_addr = '0;
      for (int i = 0; i < TAPS; i++) hist[i] = '0;
    end else begin
      exp_done = 1'b0;
      if (phase == 0) begin
        if (clear) begin
          for (int i = 0; i < TAPS; i++) hist[i] = '0;
        end else if (start) begin
          for (int i = TAPS-1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = x_in;
          pend_y = modelY();
          phase = 1;
          exp_addr = '0;
        end
      end else begin
        phase++;
        if (phase == LAT) begin
          phase = 0; exp_done = 1'b1; exp_y = pend_y;
        end else if (phase >= 2) begin
          exp_addr = ADDR_W'((phase - 1 < TAPS - 1) ? phase - 1 : TAPS - 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("done", 32'(done), 32'(exp_done));
      checkOutput("busy", 32'(busy), 32'(phase != 0));
      checkOutput("coef_addr", 32'(coef_addr), 32'(exp_addr));
      checkOutput("y_out", 32'(y_out), 32'(exp_y));
    end
  end

  // Called at a negedge; returns at the negedge of the following cycle.
  task automatic applyStimulus(input logic s, input logic c, input logic [N-1:0] x);
    start = s; clear = c; x_in = x;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDone(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic doSample(input string tag, input logic [N-1:0] x);
    int lat;
    applyStimulus(1'b1, 1'b0, x);
    waitDone(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask

  task automatic setRom(input logic [N-1:0] c0, input logic [N-1:0] rest);
    rom[0] = c0;
    for (int i = 1; i < TAPS; i++) rom[i] = rest;
  endtask

  task automatic runImpulse(input string tag);
    for (int i = 0; i < 10; i++) begin
      doSample(tag, (i == 0) ? 16'h0100 : 16'h0000);
      checkOutput({tag, "_y"}, 32'(y_out), (i < 8) ? 32'h0020 : 32'h0000);
    end
  endtask

  initial begin
    int cnt;
    int lat;
    setRom(16'h0020, 16'h0020);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_y", 32'(y_out), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_addr", 32'(coef_addr), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] impulse");
    runImpulse("s1");

    $display("[TB] rounding");
    setRom(16'h0080, 16'h0000);
    applyStimulus(1'b0, 1'b1, '0);
    doSample("s2a", 16'h0001);
    checkOutput("s2a_y", 32'(y_out), 32'h0001);
    applyStimulus(1'b0, 1'b1, '0);
    doSample("s2b", 16'hFFFF);
    checkOutput("s2b_y", 32'(y_out), 32'h0000);

    $display("[TB] overflow");
    setRom(16'h7FFF, 16'h7FFF);
    applyStimulus(1'b0, 1'b1, '0);
    for (int i = 0; i < TAPS; i++) doSample("s3p", 16'h7FFF);
`ifdef MAC_SAT_EN
    checkOutput("s3p_y", 32'(y_out), 32'h7FFF);
`else
    checkOutput("s3p_y", 32'(y_out), 32'hF800);
`endif
    applyStimulus(1'b0, 1'b1, '0);
    for (int i = 0; i < TAPS; i++) doSample("s3n", 16'h8000);
`ifdef MAC_SAT_EN
    checkOutput("s3n_y", 32'(y_out), 32'h8000);
`else
    checkOutput("s3n_y", 32'(y_out), 32'h0400);
`endif

    $display("[TB] start while busy");
    setRom(16'h0020, 16'h0020);
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 16'h0100);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h4321);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (done === 1'b1) cnt++;
      @(negedge clk);
    end
    checkOutput("s4_done_count", 32'(cnt), 32'd1);
    checkOutput("s4_y", 32'(y_out), 32'h0020);
    doSample("s4b", 16'h0000);
    checkOutput("s4b_y", 32'(y_out), 32'h0020);

    $display("[TB] reset during MAC");
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b0, 16'h0100);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("s5_rst_y", 32'(y_out), 32'h0);
    checkOutput("s5_rst_busy", 32'(busy), 32'h0);
    checkOutput("s5_rst_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    checkOutput("s5_no_done", 32'(cnt), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0100);
    waitDone(lat);
    checkOutput("s5_latency", 32'(lat), 32'(LAT));
    checkOutput("s5_y", 32'(y_out), 32'h0020);

    $display("[TB] clear with start");
    applyStimulus(1'b1, 1'b1, 16'h0100);
    checkOutput("s6_busy", 32'(busy), 32'h0);
    runImpulse("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
